ej32_boot_loader: RTL and testbench

Boot-time reader for the eForth ROM image. After `start`, it streams `IMG_SZ` bytes out of the 8K EBR ROM through its read port (`rom_en`, `rom_a`, `rom_d`) and writes each byte into working RAM at `RAM_BASE + offset` over a byte-wide write port with a grant handshake. It keeps an 8-bit additive checksum of the copied bytes. It sits between the ROM and the RAM arbiter, and holds the core off until `done`.

---
 rtl/ej32_boot_loader_if.sv | 31 +++
 rtl/ej32_boot_loader.sv | 96 +++++++++
 tb/tb_ej32_boot_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ej32_boot_loader_if.sv
// ROM read port and RAM byte-write port between the boot loader and its neighbours.
// The loader drives the ROM address/enable and the RAM write side; the ROM and arbiter drive the rest.
interface ej32_boot_loader_if;
    logic        rom_en;
    logic [31:0] rom_a;
    logic [7:0]  rom_d;
    logic        ram_gnt;
    logic        ram_we;
    logic [31:0] ram_a;
    logic [7:0]  ram_d;

    modport master (
        output rom_en,
        output rom_a,
        input  rom_d,
        input  ram_gnt,
        output ram_we,
        output ram_a,
        output ram_d
    );

    modport slave (
        input  rom_en,
        input  rom_a,
        output rom_d,
        output ram_gnt,
        input  ram_we,
        input  ram_a,
        input  ram_d
    );
endinterface

// File: rtl/ej32_boot_loader.sv
// Copies the eForth image from EBR ROM into working RAM at boot and keeps an additive checksum.
// The core is held off until done_o rises.
module ej32_boot_loader #(
    parameter int unsigned ROM_SZ   = 8192,
    parameter int unsigned IMG_SZ   = 8192,
    parameter logic [31:0] RAM_BASE = 32'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    ej32_boot_loader_if.master         mem_io,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [7:0]                 sum_o
);

    localparam int unsigned PW = $clog2(IMG_SZ) + 1;
    localparam logic [PW-1:0] ImgEnd = PW'(IMG_SZ);
    localparam logic [PW-1:0] LastWr = PW'(IMG_SZ - 1);

    if (IMG_SZ == 0 || IMG_SZ > ROM_SZ) begin : g_bad_size
        $error("ej32_boot_loader: IMG_SZ must be in 1..ROM_SZ");
    end

    typedef enum logic [1:0] {StIdle, StFill, StCopy, StDone} state_e;

    state_e        state_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [7:0]    sum_q;
    logic          rd_more;

    assign rd_more = (rd_ptr_q < ImgEnd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            sum_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        rd_ptr_q <= '0;
                        wr_ptr_q <= '0;
                        sum_q    <= '0;
                        state_q  <= StFill;
                    end
                end
                StFill: begin
                    // Byte 0 is being fetched this cycle, so the next fetch is byte 1.
                    rd_ptr_q <= PW'(1);
                    state_q  <= StCopy;
                end
                StCopy: begin
                    if (mem_io.ram_gnt) begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        sum_q    <= sum_q + mem_io.rom_d;
                        if (rd_more) begin
                            rd_ptr_q <= rd_ptr_q + PW'(1);
                        end
                        if (wr_ptr_q == LastWr) begin
                            state_q <= StDone;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A stall drops rom_en so the ROM keeps presenting the byte still waiting for its grant.
    always_comb begin
        mem_io.rom_en = 1'b0;
        mem_io.ram_we = 1'b0;
        mem_io.ram_a  = '0;
        mem_io.ram_d  = '0;
        unique case (state_q)
            StFill: mem_io.rom_en = 1'b1;
            StCopy: begin
                mem_io.rom_en = mem_io.ram_gnt & rd_more;
                mem_io.ram_we = mem_io.ram_gnt;
                mem_io.ram_a  = RAM_BASE + 32'(wr_ptr_q);
                mem_io.ram_d  = mem_io.rom_d;
            end
            default: ;
        endcase
    end

    assign mem_io.rom_a = 32'(rd_ptr_q);
    assign busy_o       = (state_q == StFill) || (state_q == StCopy);
    assign done_o       = (state_q == StDone);
    assign sum_o        = sum_q;

endmodule

// File: tb/tb_ej32_boot_loader.sv
// Directed bench for ej32_boot_loader: 16-byte image at RAM 0x100 with a behavioural ROM and RAM.
// Expected values come from the bench's own ROM contents and cycle arithmetic.
module tb_ej32_boot_loader;

    localparam int unsigned IMG  = 16;
    localparam logic [31:0] BASE = 32'h100;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] sum;

    int checks   = 0;
    int failures = 0;

    ej32_boot_loader_if bus ();

    ej32_boot_loader #(
        .ROM_SZ  (8192),
        .IMG_SZ  (IMG),
        .RAM_BASE(BASE)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .mem_io (bus.master),
        .busy_o (busy),
        .done_o (done),
        .sum_o  (sum)
    );

    logic [7:0] rom  [0:255];
    logic [7:0] ram  [0:511];
    int         wcnt [0:511];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_d <= rom[bus.rom_a[7:0]];
    end

    always @(posedge clk) begin
        if (bus.ram_we && bus.ram_gnt) begin
            ram[bus.ram_a[8:0]]  <= bus.ram_d;
            wcnt[bus.ram_a[8:0]] <= wcnt[bus.ram_a[8:0]] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rom_en"}, 32'(bus.rom_en), 0);
        chk({tag, " rom_a"},  bus.rom_a, 0);
        chk({tag, " ram_we"}, 32'(bus.ram_we), 0);
        chk({tag, " ram_a"},  bus.ram_a, 0);
        chk({tag, " ram_d"},  32'(bus.ram_d), 0);
        chk({tag, " busy"},   32'(busy), 0);
        chk({tag, " done"},   32'(done), 0);
        chk({tag, " sum"},    32'(sum), 0);
    endtask

    // Full copy from start; stall window [st_from, st_from+st_len) in cycle numbers, start
    // re-pulsed in cycle start_at, grant held low through cycles 0-1 when fill_low is set.
    task automatic run_copy(input string tag, input int st_from, input int st_len,
                            input bit fill_low, input int start_at,
                            input logic [7:0] exp_sum, input int exp_done);
        int k;
        int c;
        int bad;
        int base [IMG];
        bit stall;
        for (int i = 0; i < IMG; i++) base[i] = wcnt[BASE[8:0] + 9'(i)];
        k = 0;
        bus.ram_gnt = !fill_low;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.ram_gnt = !fill_low;
        #1;
        chk({tag, " fill busy"},   32'(busy), 1);
        chk({tag, " fill done"},   32'(done), 0);
        chk({tag, " fill rom_en"}, 32'(bus.rom_en), 1);
        chk({tag, " fill rom_a"},  bus.rom_a, 0);
        chk({tag, " fill ram_we"}, 32'(bus.ram_we), 0);
        tick();
        c = 2;
        while (k < IMG && c < 100) begin
            stall = (c >= st_from) && (c < st_from + st_len);
            bus.ram_gnt = !stall;
            start = (c == start_at);
            #1;
            chk({tag, " ram_we"}, 32'(bus.ram_we), 32'(!stall));
            chk({tag, " ram_a"},  bus.ram_a, BASE + 32'(k));
            chk({tag, " ram_d"},  32'(bus.ram_d), 32'(rom[k]));
            chk({tag, " rom_en"}, 32'(bus.rom_en), 32'(!stall && (k + 1 < IMG)));
            chk({tag, " busy"},   32'(busy), 1);
            if (!stall) k++;
            tick();
            start = 1'b0;
            c++;
        end
        bus.ram_gnt = 1'b1;
        chk({tag, " done cycle"}, 32'(c), 32'(exp_done));
        chk({tag, " done"},       32'(done), 1);
        chk({tag, " done busy"},  32'(busy), 0);
        chk({tag, " sum"},        32'(sum), 32'(exp_sum));
        chk({tag, " done rom_en"}, 32'(bus.rom_en), 0);
        chk({tag, " done ram_we"}, 32'(bus.ram_we), 0);
        bad = 0;
        for (int i = 0; i < IMG; i++) begin
            if (wcnt[BASE[8:0] + 9'(i)] - base[i] != 1) bad++;
            if (ram[BASE[8:0] + 9'(i)] !== rom[i]) bad++;
        end
        chk({tag, " ram image"}, 32'(bad), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.ram_gnt = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
        for (int i = 0; i < 512; i++) begin
            ram[i]  = 8'h00;
            wcnt[i] = 0;
        end
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        run_copy("basic", 0, 0, 1'b0, -1, 8'h78, 18);
        run_copy("restart", 0, 0, 1'b0, -1, 8'h78, 18);
        run_copy("stall", 7, 3, 1'b0, -1, 8'h78, 21);
        run_copy("busy start", 0, 0, 1'b0, 5, 8'h78, 18);
        run_copy("fill low", 0, 0, 1'b1, -1, 8'h78, 18);

        // Reset landing on the write of byte 7 (cycle 9).
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("midrst ram_a", bus.ram_a, BASE + 32'h7);
        chk("midrst ram_we", 32'(bus.ram_we), 1);
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        tick();
        chk_zero("midrst idle");
        run_copy("after rst", 0, 0, 1'b0, -1, 8'h78, 18);

        // Reset and start together from DONE.
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("rst+start busy", 32'(busy), 0);
        chk("rst+start done", 32'(done), 0);
        tick();
        chk("rst+start later busy", 32'(busy), 0);

        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        run_copy("wrap", 0, 0, 1'b0, -1, 8'hF0, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
